// File: rtl/temporizador_calentamiento_pkg.sv
// Shared encodings for the oven controller slice: upstream Estado codes,
// countdown FSM states and BCD digit limits.
package temporizador_calentamiento_pkg;

    localparam logic [3:0] EST_INICIO   = 4'b0000;
    localparam logic [3:0] EST_AJUSTE   = 4'b0001;
    localparam logic [3:0] EST_CALENTAR = 4'b0100;

    localparam logic [3:0] BCD_NUEVE = 4'd9;
    localparam logic [3:0] BCD_CINCO = 4'd5;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        AJUSTE     = 2'd1,
        CALENTANDO = 2'd2,
        FIN        = 2'd3
    } estado_t;

endpackage

// File: rtl/temporizador_calentamiento_divisor_segundo.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled and flags the
// terminal count for one cycle; held at zero whenever disabled.
module divisor_segundo #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int              W          = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [W-1:0]    CUENTA_FIN = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] cuenta;

    assign tick = en && (cuenta == CUENTA_FIN);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            cuenta <= '0;
        end else if (!en || tick) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + W'(1);
        end
    end

endmodule

// File: rtl/temporizador_calentamiento.sv
// Cooking-time register: MM:SS set with buttons in ajuste, BCD countdown in
// calentar, heater enable and finish flag decoded from the registered state.
//
//  state      | meaning
//  REPOSO     | idle, time held, prescaler cleared
//  AJUSTE     | buttons edit minutes/seconds
//  CALENTANDO | heater on, one decrement per prescaler tick
//  FIN        | time reached 00:00, fin asserted until Estado leaves calentar
module temporizador_calentamiento
    import temporizador_calentamiento_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int MAX_MIN       = 99
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [3:0] Estado,
    input  logic       btn_min,
    input  logic       btn_seg,
    output logic [3:0] min_dec,
    output logic [3:0] min_uni,
    output logic [3:0] seg_dec,
    output logic [3:0] seg_uni,
    output logic       calentar_en,
    output logic       fin
);

    localparam logic [3:0] MAX_DEC = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_UNI = 4'(MAX_MIN % 10);

    estado_t    est_q, est_d;
    logic       btn_min_q, btn_seg_q;
    logic       tick;
    logic [3:0] min_dec_d, min_uni_d, seg_dec_d, seg_uni_d;
    logic [3:0] inc_min_dec, inc_min_uni, inc_seg_dec, inc_seg_uni;
    logic [3:0] dec_min_dec, dec_min_uni, dec_seg_dec, dec_seg_uni;

    wire es_ajuste   = (Estado == EST_AJUSTE);
    wire es_calentar = (Estado == EST_CALENTAR);
    wire pulso_min   = btn_min & ~btn_min_q;
    wire pulso_seg   = btn_seg & ~btn_seg_q;
    wire tiempo_cero = (min_dec == 4'd0) && (min_uni == 4'd0) &&
                       (seg_dec == 4'd0) && (seg_uni == 4'd0);
    wire dec_cero    = (dec_min_dec == 4'd0) && (dec_min_uni == 4'd0) &&
                       (dec_seg_dec == 4'd0) && (dec_seg_uni == 4'd0);

    divisor_segundo #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_divisor (
        .Clk     (Clk),
        .reset_n (reset_n),
        .en      (est_q == CALENTANDO),
        .tick    (tick)
    );

    // Minute and second increments wrap independently; no carry between them.
    always_comb begin
        inc_min_dec = min_dec;
        inc_min_uni = min_uni + 4'd1;
        if (min_dec == MAX_DEC && min_uni == MAX_UNI) begin
            inc_min_dec = 4'd0;
            inc_min_uni = 4'd0;
        end else if (min_uni == BCD_NUEVE) begin
            inc_min_dec = min_dec + 4'd1;
            inc_min_uni = 4'd0;
        end
        inc_seg_dec = seg_dec;
        inc_seg_uni = seg_uni + 4'd1;
        if (seg_dec == BCD_CINCO && seg_uni == BCD_NUEVE) begin
            inc_seg_dec = 4'd0;
            inc_seg_uni = 4'd0;
        end else if (seg_uni == BCD_NUEVE) begin
            inc_seg_dec = seg_dec + 4'd1;
            inc_seg_uni = 4'd0;
        end
    end

    // Borrow chain; only used while the time is non-zero.
    always_comb begin
        dec_min_dec = min_dec;
        dec_min_uni = min_uni;
        dec_seg_dec = seg_dec;
        dec_seg_uni = seg_uni - 4'd1;
        if (seg_uni == 4'd0) begin
            dec_seg_uni = BCD_NUEVE;
            dec_seg_dec = seg_dec - 4'd1;
            if (seg_dec == 4'd0) begin
                dec_seg_dec = BCD_CINCO;
                dec_min_uni = min_uni - 4'd1;
                if (min_uni == 4'd0) begin
                    dec_min_uni = BCD_NUEVE;
                    dec_min_dec = min_dec - 4'd1;
                end
            end
        end
    end

    always_comb begin
        est_d     = est_q;
        min_dec_d = min_dec;
        min_uni_d = min_uni;
        seg_dec_d = seg_dec;
        seg_uni_d = seg_uni;
        case (est_q)
            REPOSO: begin
                if (es_ajuste) begin
                    est_d = AJUSTE;
                end else if (es_calentar) begin
                    est_d = tiempo_cero ? FIN : CALENTANDO;
                end
            end
            AJUSTE: begin
                if (!es_ajuste) begin
                    est_d = REPOSO;
                end else begin
                    if (pulso_min) begin
                        min_dec_d = inc_min_dec;
                        min_uni_d = inc_min_uni;
                    end
                    if (pulso_seg) begin
                        seg_dec_d = inc_seg_dec;
                        seg_uni_d = inc_seg_uni;
                    end
                end
            end
            CALENTANDO: begin
                if (tick) begin
                    min_dec_d = dec_min_dec;
                    min_uni_d = dec_min_uni;
                    seg_dec_d = dec_seg_dec;
                    seg_uni_d = dec_seg_uni;
                end
                // A pause wins over reaching zero: the decrement lands, FSM idles.
                if (!es_calentar) begin
                    est_d = REPOSO;
                end else if (tick && dec_cero) begin
                    est_d = FIN;
                end
            end
            FIN: begin
                if (!es_calentar) begin
                    est_d = REPOSO;
                end
            end
            default: est_d = REPOSO;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            est_q       <= REPOSO;
            btn_min_q   <= 1'b0;
            btn_seg_q   <= 1'b0;
            min_dec     <= 4'd0;
            min_uni     <= 4'd0;
            seg_dec     <= 4'd0;
            seg_uni     <= 4'd0;
            calentar_en <= 1'b0;
            fin         <= 1'b0;
        end else begin
            est_q       <= est_d;
            btn_min_q   <= btn_min;
            btn_seg_q   <= btn_seg;
            min_dec     <= min_dec_d;
            min_uni     <= min_uni_d;
            seg_dec     <= seg_dec_d;
            seg_uni     <= seg_uni_d;
            calentar_en <= (est_d == CALENTANDO);
            fin         <= (est_d == FIN);
        end
    end

endmodule

// File: tb/tb_temporizador_calentamiento.sv
// Bench for temporizador_calentamiento: directed scenarios plus random traffic,
// every cycle compared against a seconds-arithmetic reference model.
module tb_temporizador_calentamiento;

    localparam int TPS     = 4;
    localparam int MAX_MIN = 99;

    localparam int M_REPOSO = 0;
    localparam int M_AJUSTE = 1;
    localparam int M_CAL    = 2;
    localparam int M_FIN    = 3;

    logic       Clk;
    logic       reset_n;
    logic [3:0] Estado;
    logic       btn_min, btn_seg;
    logic [3:0] min_dec, min_uni, seg_dec, seg_uni;
    logic       calentar_en, fin;

    int n_tests = 0;
    int n_fail  = 0;

    int m_min, m_seg, m_modo, m_presc;
    bit m_pmin, m_pseg;

    temporizador_calentamiento #(.TICKS_PER_SEC(TPS), .MAX_MIN(MAX_MIN)) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .Estado      (Estado),
        .btn_min     (btn_min),
        .btn_seg     (btn_seg),
        .min_dec     (min_dec),
        .min_uni     (min_uni),
        .seg_dec     (seg_dec),
        .seg_uni     (seg_uni),
        .calentar_en (calentar_en),
        .fin         (fin)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic comprobar(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        n_tests++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: obtenido %h esperado %h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [15:0] digitos();
        return {min_dec, min_uni, seg_dec, seg_uni};
    endfunction

    function automatic logic [15:0] modelo_digitos();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_seg / 10), 4'(m_seg % 10)};
    endfunction

    task automatic modelo_reset();
        m_min = 0; m_seg = 0; m_modo = M_REPOSO; m_presc = 0;
        m_pmin = 1'b0; m_pseg = 1'b0;
    endtask

    task automatic modelo_paso();
        bit pm, ps, tk;
        int t;
        pm = btn_min && !m_pmin;
        ps = btn_seg && !m_pseg;
        t  = 1;
        case (m_modo)
            M_REPOSO: begin
                m_presc = 0;
                if (Estado == 4'b0001) m_modo = M_AJUSTE;
                else if (Estado == 4'b0100) m_modo = (m_min == 0 && m_seg == 0) ? M_FIN : M_CAL;
            end
            M_AJUSTE: begin
                if (Estado != 4'b0001) m_modo = M_REPOSO;
                else begin
                    if (pm) m_min = (m_min + 1) % (MAX_MIN + 1);
                    if (ps) m_seg = (m_seg + 1) % 60;
                end
            end
            M_CAL: begin
                tk = (m_presc == TPS - 1);
                m_presc = tk ? 0 : m_presc + 1;
                if (tk) begin
                    t = m_min * 60 + m_seg - 1;
                    m_min = t / 60;
                    m_seg = t % 60;
                end
                if (Estado != 4'b0100) m_modo = M_REPOSO;
                else if (tk && t == 0) m_modo = M_FIN;
            end
            default: if (Estado != 4'b0100) m_modo = M_REPOSO;
        endcase
        m_pmin = btn_min;
        m_pseg = btn_seg;
    endtask

    task automatic verificar_salidas(input string tag);
        comprobar({tag, "_dig"}, digitos(), modelo_digitos());
        comprobar({tag, "_en"},  16'(calentar_en), 16'(m_modo == M_CAL));
        comprobar({tag, "_fin"}, 16'(fin), 16'(m_modo == M_FIN));
    endtask

    task automatic paso();
        @(posedge Clk);
        modelo_paso();
        #1;
        verificar_salidas("ciclo");
    endtask

    task automatic pulsar(input bit bmin, input bit bseg);
        btn_min = bmin;
        btn_seg = bseg;
        repeat (10) paso();
        btn_min = 1'b0;
        btn_seg = 1'b0;
        repeat (2) paso();
    endtask

    task automatic reset_async(input string tag);
        reset_n = 1'b0;
        modelo_reset();
        #1;
        comprobar({tag, "_dig"}, digitos(), 16'h0000);
        comprobar({tag, "_en"},  16'(calentar_en), 16'h0000);
        comprobar({tag, "_fin"}, 16'(fin), 16'h0000);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        Estado  = 4'b0000;
        btn_min = 1'b0;
        btn_seg = 1'b0;
        modelo_reset();
        #12;
        reset_async("reset_inicial");
        paso();

        // Adjust: 3 seconds, 2 minutes, then seconds up to 59 and wrap.
        Estado = 4'b0001;
        repeat (2) paso();
        repeat (3) pulsar(1'b0, 1'b1);
        repeat (2) pulsar(1'b1, 1'b0);
        comprobar("ajuste_0203", digitos(), 16'h0203);
        repeat (56) pulsar(1'b0, 1'b1);
        comprobar("ajuste_0259", digitos(), 16'h0259);
        pulsar(1'b0, 1'b1);
        comprobar("seg_wrap_0200", digitos(), 16'h0200);

        // Minute wrap and simultaneous presses.
        repeat (97) pulsar(1'b1, 1'b0);
        comprobar("min_99", digitos(), 16'h9900);
        pulsar(1'b1, 1'b0);
        comprobar("min_wrap_00", digitos(), 16'h0000);
        repeat (5) pulsar(1'b0, 1'b1);
        pulsar(1'b1, 1'b1);
        comprobar("simultaneo_0106", digitos(), 16'h0106);

        // Countdown from 01:00.
        repeat (54) pulsar(1'b0, 1'b1);
        comprobar("ajuste_0100", digitos(), 16'h0100);
        Estado = 4'b0000;
        repeat (2) paso();
        Estado = 4'b0100;
        paso();
        comprobar("cuenta_en_1clk", 16'(calentar_en), 16'h0001);
        repeat (3) paso();
        comprobar("cuenta_antes_tick", digitos(), 16'h0100);
        paso();
        comprobar("cuenta_0059", digitos(), 16'h0059);
        repeat (235) paso();
        comprobar("cuenta_0001", digitos(), 16'h0001);
        comprobar("cuenta_0001_en", 16'(calentar_en), 16'h0001);
        paso();
        comprobar("cuenta_0000", digitos(), 16'h0000);
        comprobar("cuenta_fin", 16'(fin), 16'h0001);
        comprobar("cuenta_fin_en", 16'(calentar_en), 16'h0000);

        // Pause and resume at 00:30.
        Estado = 4'b0001;
        repeat (2) paso();
        repeat (30) pulsar(1'b0, 1'b1);
        Estado = 4'b0000;
        repeat (2) paso();
        Estado = 4'b0100;
        repeat (2) paso();
        Estado = 4'b0000;
        repeat (20) paso();
        comprobar("pausa_0030", digitos(), 16'h0030);
        comprobar("pausa_en", 16'(calentar_en), 16'h0000);
        Estado = 4'b0100;
        paso();
        repeat (3) paso();
        comprobar("reanuda_sin_tick", digitos(), 16'h0030);
        paso();
        comprobar("reanuda_0029", digitos(), 16'h0029);

        // Reset in the middle of a countdown.
        repeat (2) paso();
        reset_async("reset_en_cuenta");
        Estado = 4'b0000;
        paso();

        // Zero start goes straight to FIN; illegal code 0110 behaves as inicio.
        Estado = 4'b0100;
        paso();
        comprobar("cero_fin", 16'(fin), 16'h0001);
        comprobar("cero_en", 16'(calentar_en), 16'h0000);
        repeat (6) paso();
        Estado = 4'b0000;
        paso();
        comprobar("cero_sale_fin", 16'(fin), 16'h0000);
        Estado = 4'b0110;
        pulsar(1'b1, 1'b1);
        comprobar("ilegal_dig", digitos(), 16'h0000);
        comprobar("ilegal_en", 16'(calentar_en | fin), 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: Estado = 4'b0000;
                    1: Estado = 4'b0001;
                    2: Estado = 4'b0100;
                    3: Estado = 4'b0110;
                    default: Estado = 4'(4'($urandom_range(0, 15)));
                endcase
            end
            btn_min = ($urandom_range(0, 3) == 0);
            btn_seg = ($urandom_range(0, 3) == 0);
            paso();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
